// File: rtl/addpkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// addpkg : shared widths and sequencer states for the FP alignment path
// Rev 1.0
// ----------------------------------------------------------------------------
package addpkg;

  localparam int SIG_W     = 24;
  localparam int ALN_W     = 27;
  localparam int MAX_SHIFT = 27;
  localparam int CNT_W     = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sticky_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sticky_shifter : right shift by s, folding every lost bit into bit 0
// Rev 1.0
// ----------------------------------------------------------------------------
module sticky_shifter
  import addpkg::*;
(
  input  logic [ALN_W-1:0] value,
  input  logic [CNT_W-1:0] s,
  output logic [ALN_W-1:0] shifted
);

  logic [ALN_W-1:0] w_mask;
  logic             w_lost;

  always_comb begin
    w_mask  = ~({ALN_W{1'b1}} << s);
    w_lost  = |(value & w_mask);
    shifted = (value >> s) | {{(ALN_W-1){1'b0}}, w_lost};
  end

endmodule
`default_nettype wire

// File: rtl/align_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// align_sequencer : multi-cycle exponent compare and significand alignment
// Rev 1.0
// ----------------------------------------------------------------------------
module align_sequencer
  import addpkg::*;
#(
  parameter int STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] sig_big,
  output logic [ALN_W-1:0] sig_small_aln,
  output logic [7:0]       exp_big,
  output logic             sign_big,
  output logic             sign_small,
  output logic             swapped
);

  localparam logic [CNT_W-1:0] c_step = CNT_W'(STEP);

  state_t           r_state;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [CNT_W-1:0] r_rem;
  logic [ALN_W-1:0] r_small;
  logic [SIG_W-1:0] r_sig_big;
  logic [7:0]       r_exp_big;
  logic             r_sign_big;
  logic             r_sign_small;
  logic             r_swapped;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [7:0]       w_eff_a;
  logic [7:0]       w_eff_b;
  logic             w_b_big;
  logic [7:0]       w_diff;
  logic [CNT_W-1:0] w_dclamp;
  logic [31:0]      w_big;
  logic [31:0]      w_sml;
  logic [CNT_W-1:0] w_s;
  logic [CNT_W-1:0] w_rem_next;
  logic [ALN_W-1:0] w_shifted;

  // Denormals use an effective exponent of 1 so the diff stays correct.
  always_comb begin
    w_eff_a    = (r_op_a[30:23] == 8'd0) ? 8'd1 : r_op_a[30:23];
    w_eff_b    = (r_op_b[30:23] == 8'd0) ? 8'd1 : r_op_b[30:23];
    w_b_big    = (w_eff_b > w_eff_a);
    w_big      = w_b_big ? r_op_b : r_op_a;
    w_sml      = w_b_big ? r_op_a : r_op_b;
    w_diff     = w_b_big ? (w_eff_b - w_eff_a) : (w_eff_a - w_eff_b);
    w_dclamp   = (w_diff > 8'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : w_diff[CNT_W-1:0];
    w_s        = (r_rem < c_step) ? r_rem : c_step;
    w_rem_next = r_rem - w_s;
  end

  sticky_shifter u_sticky_shifter (
    .value   (r_small),
    .s       (w_s),
    .shifted (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rem        <= '0;
      r_small      <= '0;
      r_sig_big    <= '0;
      r_exp_big    <= '0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_swapped    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op_a     <= op_a;
            r_op_b     <= op_b;
            r_in_ready <= 1'b0;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          r_sig_big    <= {|w_big[30:23], w_big[22:0]};
          r_exp_big    <= w_b_big ? w_eff_b : w_eff_a;
          r_sign_big   <= w_big[31];
          r_sign_small <= w_sml[31];
          r_swapped    <= w_b_big;
          r_small      <= {|w_sml[30:23], w_sml[22:0], 3'b000};
          r_rem        <= w_dclamp;
          if (w_dclamp == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          r_small <= w_shifted;
          r_rem   <= w_rem_next;
          if (w_rem_next == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign sig_big       = r_sig_big;
  assign sig_small_aln = r_small;
  assign exp_big       = r_exp_big;
  assign sign_big      = r_sign_big;
  assign sign_small    = r_sign_small;
  assign swapped       = r_swapped;

endmodule
`default_nettype wire

// File: tb/tb_align_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_align_sequencer : directed and random checks against a reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_align_sequencer;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] sig_big;
  logic [26:0] sig_small_aln;
  logic [7:0]  exp_big;
  logic        sign_big;
  logic        sign_small;
  logic        swapped;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  align_sequencer #(.STEP(STEP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sig_big       (sig_big),
    .sig_small_aln (sig_small_aln),
    .exp_big       (exp_big),
    .sign_big      (sign_big),
    .sign_small    (sign_small),
    .swapped       (swapped)
  );

  typedef struct packed {
    logic        swp;
    logic [7:0]  eb;
    logic [23:0] sb;
    logic [26:0] ss;
    logic        sgb;
    logic        sgs;
    logic [31:0] lat;
  } exp_t;

  // Whole-operation result straight from the alignment rules, no stepping.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    int          effa, effb, d;
    logic [31:0] big, sml;
    logic [26:0] v;
    effa  = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    effb  = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    e.swp = (effb > effa);
    big   = e.swp ? b : a;
    sml   = e.swp ? a : b;
    e.eb  = e.swp ? 8'(effb) : 8'(effa);
    e.sb  = {|big[30:23], big[22:0]};
    d     = e.swp ? effb - effa : effa - effb;
    if (d > 27) d = 27;
    v     = {|sml[30:23], sml[22:0], 3'b000};
    e.ss  = v >> d;
    if ((v & ((27'd1 << d) - 27'd1)) != 27'd0) e.ss[0] = 1'b1;
    e.sgb = big[31];
    e.sgs = sml[31];
    e.lat = 32'(1 + (d + STEP - 1) / STEP);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".swapped"}, 32'(swapped), 32'(e.swp));
    chk({tag, ".exp_big"}, 32'(exp_big), 32'(e.eb));
    chk({tag, ".sig_big"}, 32'(sig_big), 32'(e.sb));
    chk({tag, ".sig_small_aln"}, 32'(sig_small_aln), 32'(e.ss));
    chk({tag, ".sign_big"}, 32'(sign_big), 32'(e.sgb));
    chk({tag, ".sign_small"}, 32'(sign_small), 32'(e.sgs));
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit busy, output int lat);
    exp_t e;
    e = model(a, b);
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = busy;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (busy) begin op_a = $urandom; op_b = $urandom; end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), e.lat);
    check_outputs(tag, e);
    for (int k = 0; k < stall; k++) begin
      out_ready = 1'b0;
      if (busy) begin op_a = $urandom; op_b = $urandom; end
      @(posedge clk); #1;
      check_outputs({tag, ".stall"}, e);
      chk({tag, ".in_ready_stall"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".out_valid_post"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_post"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   lat;
    int   ea, eb;
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.swapped", 32'(swapped), 32'd0);
    chk("rst.sig_big", 32'(sig_big), 32'd0);
    chk("rst.sig_small_aln", 32'(sig_small_aln), 32'd0);
    chk("rst.exp_big", 32'(exp_big), 32'd0);

    // in_valid while reset is asserted must not start an operation
    op_a = 32'h40000000; op_b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid.in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid.in_ready2", 32'(in_ready), 32'd1);
    chk("rst_valid.out_valid", 32'(out_valid), 32'd0);

    run_op("r029", 32'h40000000, 32'h3F800000, 1, 1'b0, lat);
    chk("r029.edge", 32'(lat), 32'd2);
    run_op("r030", 32'h3F800000, 32'h40000000, 0, 1'b0, lat);
    chk("r030.edge", 32'(lat), 32'd2);
    run_op("r031", 32'h4B000000, 32'h3F800001, 2, 1'b0, lat);
    chk("r031.edge", 32'(lat), 32'd7);
    run_op("r032", 32'h4F800000, 32'h3F800000, 0, 1'b0, lat);
    chk("r032.edge", 32'(lat), 32'd8);
    run_op("equal", 32'hC1200000, 32'h41300000, 0, 1'b0, lat);
    chk("equal.edge", 32'(lat), 32'd1);
    run_op("r033", 32'h4B000000, 32'h3F800001, 5, 1'b1, lat);
    run_op("r033_next", 32'h40000000, 32'h3F800000, 0, 1'b0, lat);

    // reset in the middle of SHIFT
    op_a = 32'h4B000000; op_b = 32'h3F800001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("r034.mid_valid", 32'(out_valid), 32'd0);
    chk("r034.mid_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("r034.out_valid", 32'(out_valid), 32'd0);
    chk("r034.in_ready", 32'(in_ready), 32'd1);
    chk("r034.swapped", 32'(swapped), 32'd0);
    chk("r034.sig_small_aln", 32'(sig_small_aln), 32'd0);
    run_op("r034_fresh", 32'h40000000, 32'h3F800000, 0, 1'b0, lat);

    for (int i = 0; i < 24; i++) begin
      ea = int'($urandom_range(0, 255));
      if (i % 3 == 0) eb = int'($urandom_range(0, 255));
      else            eb = ea + int'($urandom_range(0, 30)) - 15;
      if (eb < 0)   eb = 0;
      if (eb > 255) eb = 255;
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      run_op("rand", ra, rb, int'($urandom_range(0, 3)), 1'(i % 4 == 1), lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
